instruction_memory_loadable: RTL and testbench
==============================================

// Module: instruction_memory_loadable
// PURPOSE
// Parametrised instruction store for the single-cycle MIPS core. It replaces the hard-coded program
// with a clear-on-reset array, a program-load port driven by the testbench or host, and a registered
// fetch port. The fetch port returns instruction, valid and fault flags.
// It sits between the PC register and the control/decode logic. The core waits for ready before it
// issues fetches.
// PARAMETERS
// DATA_WIDTH  32           instruction word width
// DEPTH       128          number of instruction words
// ADDR_WIDTH  32           width of the fetch_addr and load_addr buses
// ADDR_SHIFT  0            0 = word-addressed PC; 2 = byte-addressed PC (low 2 bits must be 0)
// FILL_WORD   32'h94000000 value written to every word on init (halt opcode 6'b100101)
// PORTS
// clock        in   1           single clock; all state updates on posedge
// reset        in   1           synchronous, active-high
// load_start   in   1           in RUN: re-enter LOAD (program reload)
// load_we      in   1           write load_data to load_addr (LOAD state only)
// load_addr    in   ADDR_WIDTH  word index for the load write
// load_data    in   DATA_WIDTH  instruction to store
// load_done    in   1           end of program load: LOAD -> RUN
// load_err     out  1           sticky: a load write was out of range; cleared on entering LOAD
// ready        out  1           1 only in RUN
// fetch_req    in   1           fetch request, sampled on posedge
// fetch_addr   in   ADDR_WIDTH  PC value
// instr_valid  out  1           response strobe, exactly 1 cycle after an accepted fetch_req
// instruction  out  DATA_WIDTH  fetched word; FILL_WORD on fault
// fetch_fault  out  1           qualifies instr_valid: address out of range or misaligned
// BEHAVIOUR
// - FSM states: INIT, LOAD, RUN. reset forces INIT from any state, including mid-load and mid-fetch.
// - Reset values: ready=0, instr_valid=0, fetch_fault=0, instruction=FILL_WORD, load_err=0,
//   init counter=0.
// - INIT writes FILL_WORD to address cnt, one word per cycle, for cnt = 0..DEPTH-1.
//   After the write at DEPTH-1 the FSM goes to LOAD. INIT lasts exactly DEPTH cycles.
// - LOAD:
//   - load_we with load_addr < DEPTH: write, visible to the first fetch in RUN.
//   - load_we with load_addr >= DEPTH: the write is dropped and load_err is set.
//   - load_done goes to RUN next cycle. load_we in the same cycle as load_done is still performed.
// - RUN:
//   - load_we is ignored.
//   - load_start goes to LOAD. load_start has priority over a fetch_req in the same cycle; that
//     fetch_req is not accepted.
// - Fetch rules:
//   - fetch_req is accepted only when ready=1 and load_start=0. When it is not accepted,
//     instr_valid=0 next cycle.
//   - Index = fetch_addr >> ADDR_SHIFT.
//   - Fault when index >= DEPTH, or when ADDR_SHIFT=2 and fetch_addr[1:0] != 0. On fault:
//     instruction=FILL_WORD and fetch_fault=1.
//   - Latency is 1 cycle. Back-to-back requests give back-to-back responses; there is no bubble.
//   - instruction holds its last value while instr_valid=0.
// - The array is single-port. INIT, load writes and fetch reads are mutually exclusive by state,
//   so no read/write collision is possible.
// - Width rules:
//   - Index compare uses the full ADDR_WIDTH; there is no truncation or wrap-around.
//   - Address 2**ADDR_WIDTH-1 faults whenever DEPTH < 2**ADDR_WIDTH.
// STRUCTURE
// - Package imem_pkg: state enum (INIT/LOAD/RUN), OP_HALT=6'b100101, default FILL_WORD.
// - Sub-module imem_ram: DEPTH x DATA_WIDTH, one synchronous write port, one synchronous read port.
// - Top level: FSM, init counter ($clog2(DEPTH)+1 bits), address mux, range/alignment check,
//   response registers.
// TESTING
// - Init: reset 1 cycle, DEPTH=128 -> ready rises after 128 cycles in INIT, a load_done pulse and
//   one LOAD->RUN cycle. Fetch addr 5 with no load -> 32'h94000000, fault=0.
// - Load/fetch: load 0:32'h98010000, 1:32'h78010001, load_done -> fetch 0,1 back-to-back ->
//   valid on two consecutive cycles with the same words in order.
// - Range: fetch 128 -> valid=1, fault=1, instr=32'h94000000. load_we addr 200 -> load_err=1,
//   memory unchanged.
// - Byte mode: ADDR_SHIFT=2, fetch 8 -> word 2; fetch 6 -> fault=1.
// - Reload and priority:
//   - load_start together with fetch_req in RUN -> instr_valid=0 next cycle, ready=0.
//   - New load then returns the new data; load_err is cleared on entry to LOAD.
// - Reset mid-operation: assert reset during LOAD and during a fetch -> outputs at reset values
//   next cycle. INIT restarts and previously loaded words read back as FILL_WORD.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the loadable instruction memory.
//   imem_state_e       : controller states (init sweep, program load, fetch service)
//   OP_HALT            : opcode of the halt instruction
//   FILL_WORD_DEFAULT  : halt instruction with zero operands, written to every word on init
package imem_pkg;

    typedef enum logic [1:0] {
        StInit,
        StLoad,
        StRun
    } imem_state_e;

    localparam logic [5:0]  OP_HALT           = 6'b100101;
    localparam logic [31:0] FILL_WORD_DEFAULT = {OP_HALT, 26'd0};

endpackage

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x DATA_WIDTH storage with one shared address.
// Writes and reads are both synchronous; the read data register holds its value
// while re is low.
// Ports:
//   clock  in   clock
//   we     in   write enable (wdata -> mem[addr])
//   re     in   read enable (mem[addr] -> rdata on the next edge)
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data
module imem_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned AW         = 7
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic                  re,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instruction_memory_loadable.sv
// instruction_memory_loadable: instruction store for the single-cycle MIPS core.
// After reset every word is swept to FILL_WORD, then a host loads the program,
// then the core fetches with a one-cycle registered response.
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   load_start              in RUN: go back to LOAD for a program reload
//   load_we/addr/data       program write (LOAD only)
//   load_done               LOAD -> RUN
//   load_err                sticky out-of-range load write flag, cleared on entering LOAD
//   ready                   high only in RUN
//   fetch_req, fetch_addr   fetch request and PC value
//   instr_valid             response strobe one cycle after an accepted fetch
//   instruction             fetched word (FILL_WORD on fault), held while instr_valid=0
//   fetch_fault             response was out of range or misaligned
module instruction_memory_loadable
    import imem_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 128,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           ADDR_SHIFT = 0,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = DATA_WIDTH'(FILL_WORD_DEFAULT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    output logic                  load_err,
    output logic                  ready,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  fetch_fault
);

    localparam int unsigned           RAM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned           CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(DEPTH - 1);
    // One extra bit so the range compare never wraps, whatever DEPTH is.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ADDR_SHIFT) - 64'd1);

    imem_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  load_err_q, load_err_d;
    logic                  valid_q, fault_q, fill_sel_q;

    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  fetch_bad, fetch_accept, load_oob;
    logic                  ram_we, ram_re;
    logic [RAM_AW-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

    assign fetch_idx    = fetch_addr >> ADDR_SHIFT;
    assign fetch_bad    = ({1'b0, fetch_idx} >= DEPTH_EXT) || ((fetch_addr & ALIGN_MASK) != '0);
    assign load_oob     = {1'b0, load_addr} >= DEPTH_EXT;
    assign ready        = (state_q == StRun);
    assign fetch_accept = ready && fetch_req && !load_start;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_err_d = load_err_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = FILL_WORD;
        unique case (state_q)
            StInit: begin
                ram_we   = 1'b1;
                ram_addr = cnt_q[RAM_AW-1:0];
                if (cnt_q == CNT_LAST) begin
                    state_d    = StLoad;
                    cnt_d      = '0;
                    load_err_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLoad: begin
                // A write in the load_done cycle still lands.
                if (load_we && !load_oob) begin
                    ram_we    = 1'b1;
                    ram_addr  = load_addr[RAM_AW-1:0];
                    ram_wdata = load_data;
                end
                if (load_we && load_oob) begin
                    load_err_d = 1'b1;
                end
                if (load_done) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (load_start) begin
                    state_d    = StLoad;
                    load_err_d = 1'b0;
                end else if (fetch_req) begin
                    // Faulting fetches leave the read register alone; the output mux
                    // substitutes FILL_WORD instead.
                    ram_re   = !fetch_bad;
                    ram_addr = fetch_idx[RAM_AW-1:0];
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            load_err_q <= 1'b0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            fill_sel_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
            valid_q    <= fetch_accept;
            fault_q    <= fetch_accept && fetch_bad;
            // Only a new response changes what instruction shows.
            if (fetch_accept) begin
                fill_sel_q <= fetch_bad;
            end
        end
    end

    imem_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (RAM_AW)
    ) u_ram (
        .clock(clock),
        .we   (ram_we && !reset),
        .re   (ram_re && !reset),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign load_err    = load_err_q;
    assign instr_valid = valid_q;
    assign fetch_fault = fault_q;
    assign instruction = fill_sel_q ? FILL_WORD : ram_rdata;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Bench: word-addressed instance (u_dut0) and byte-addressed instance (u_dut1) share the
// load interface; each has its own fetch port and its own response scoreboard.
module tb_instruction_memory_loadable;

    localparam logic [31:0] FILL = 32'h9400_0000;

    typedef struct {
        int unsigned due;
        logic        fault;
        logic [31:0] instr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0, load_we = 1'b0, load_done = 1'b0;
    logic [31:0] load_addr = '0, load_data = '0;
    logic        fetch_req0 = 1'b0, fetch_req1 = 1'b0;
    logic [31:0] fetch_addr0 = '0, fetch_addr1 = '0;
    logic        load_err0, ready0, valid0, fault0;
    logic        load_err1, ready1, valid1, fault1;
    logic [31:0] instr0, instr1;

    int          n_vec = 0, n_err = 0;
    int unsigned cyc = 0;
    logic        rst_smp = 1'b1;
    logic        run_m = 1'b0;
    logic [31:0] mem_m [128];
    logic [31:0] last0 = FILL, last1 = FILL;
    exp_t        q0[$], q1[$];

    always #5 clock = ~clock;

    instruction_memory_loadable #(.ADDR_SHIFT(0)) u_dut0 (
        .clock(clock), .reset(reset), .load_start(load_start), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .load_err(load_err0), .ready(ready0), .fetch_req(fetch_req0),
        .fetch_addr(fetch_addr0), .instr_valid(valid0), .instruction(instr0),
        .fetch_fault(fault0)
    );

    instruction_memory_loadable #(.ADDR_SHIFT(2)) u_dut1 (
        .clock(clock), .reset(reset), .load_start(load_start), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .load_err(load_err1), .ready(ready1), .fetch_req(fetch_req1),
        .fetch_addr(fetch_addr1), .instr_valid(valid1), .instruction(instr1),
        .fetch_fault(fault1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Runs once per cycle at the negedge: due responses must show up exactly then,
    // otherwise instr_valid must be low and instruction must hold.
    task automatic monitor();
        exp_t e;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            check("d0_valid", valid0, 1);
            check("d0_fault", fault0, e.fault);
            check("d0_instr", instr0, e.instr);
            last0 = e.instr;
        end else begin
            if (rst_smp) last0 = FILL;
            check("d0_idle_valid", valid0, 0);
            check("d0_hold", instr0, last0);
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            check("d1_valid", valid1, 1);
            check("d1_fault", fault1, e.fault);
            check("d1_instr", instr1, e.instr);
            last1 = e.instr;
        end else begin
            if (rst_smp) last1 = FILL;
            check("d1_idle_valid", valid1, 0);
            check("d1_hold", instr1, last1);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        monitor();
        rst_smp = reset;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Caller may have fetch/load inputs active; they are presented in the reset cycle.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        fetch_req0 = 1'b0;
        fetch_req1 = 1'b0;
        load_we    = 1'b0;
        load_start = 1'b0;
        check("rst_ready", ready0, 0);
        check("rst_valid", valid0, 0);
        check("rst_fault", fault0, 0);
        check("rst_instr", instr0, FILL);
        check("rst_load_err", load_err0, 0);
        check("rst_ready1", ready1, 0);
        for (int i = 0; i < 128; i++) mem_m[i] = FILL;
        run_m = 1'b0;
        reset = 1'b0;
    endtask

    // INIT must last exactly 128 cycles: load_done in its last cycle is ignored,
    // load_done in the first LOAD cycle enters RUN.
    task automatic init_sequence();
        repeat (127) tick();
        check("init_ready_early", ready0, 0);
        load_done = 1'b1;
        tick();
        check("init_ready_last", ready0, 0);
        tick();
        load_done = 1'b0;
        check("init_ready", ready0, 1);
        check("init_ready1", ready1, 1);
        run_m = 1'b1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic done);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        load_done = done;
        if (a < 32'd128) mem_m[a[6:0]] = d;
        tick();
        load_we   = 1'b0;
        load_done = 1'b0;
        if (done) run_m = 1'b1;
    endtask

    task automatic fetch(input logic r0, input logic [31:0] a0, input logic r1,
                         input logic [31:0] a1, input logic ls);
        exp_t        e;
        logic [31:0] idx;
        fetch_req0  = r0;
        fetch_addr0 = a0;
        fetch_req1  = r1;
        fetch_addr1 = a1;
        load_start  = ls;
        if (run_m && !ls && r0) begin
            e.due   = cyc + 1;
            e.fault = (a0 >= 32'd128);
            e.instr = e.fault ? FILL : mem_m[a0[6:0]];
            q0.push_back(e);
        end
        if (run_m && !ls && r1) begin
            idx     = a1 >> 2;
            e.due   = cyc + 1;
            e.fault = (idx >= 32'd128) || (a1[1:0] != 2'b00);
            e.instr = e.fault ? FILL : mem_m[idx[6:0]];
            q1.push_back(e);
        end
        if (ls) run_m = 1'b0;
        tick();
        fetch_req0 = 1'b0;
        fetch_req1 = 1'b0;
        load_start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem_m[i] = FILL;

        do_reset();
        init_sequence();
        fetch(1, 32'd5, 1, 32'd20, 0);
        tick();

        // load_start wins over a same-cycle fetch
        fetch(1, 32'd1, 1, 32'd4, 1);
        check("reload_ready", ready0, 0);
        load_word(32'd0, 32'h9801_0000, 0);
        load_word(32'd200, 32'hDEAD_BEEF, 0);
        check("load_err_set", load_err0, 1);
        check("load_err_set1", load_err1, 1);
        load_word(32'd1, 32'h7801_0001, 1);
        check("run_ready", ready0, 1);
        check("load_err_sticky", load_err0, 1);

        fetch(1, 32'd0, 1, 32'd0, 0);
        fetch(1, 32'd1, 1, 32'd4, 0);
        fetch(1, 32'd128, 1, 32'd8, 0);
        fetch(1, 32'd72, 1, 32'd6, 0);
        fetch(1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 0);
        fetch(1, 32'd127, 1, 32'd508, 0);
        tick();
        tick();

        // Reload: entering LOAD clears load_err, new data replaces old
        fetch(0, 32'd0, 0, 32'd0, 1);
        check("reload_err_clr", load_err0, 0);
        check("reload_ready2", ready0, 0);
        load_word(32'd0, 32'h1111_1111, 1);
        fetch(1, 32'd0, 1, 32'd0, 0);
        fetch(1, 32'd1, 1, 32'd4, 0);
        tick();

        // Reset together with a fetch request
        fetch(1, 32'd1, 1, 32'd4, 0);
        fetch_req0  = 1'b1;
        fetch_addr0 = 32'd0;
        fetch_req1  = 1'b1;
        fetch_addr1 = 32'd0;
        do_reset();
        init_sequence();

        // Reset in the middle of a load
        fetch(0, 32'd0, 0, 32'd0, 1);
        load_word(32'd3, 32'h0000_ABCD, 0);
        load_we   = 1'b1;
        load_addr = 32'd4;
        load_data = 32'h5555_5555;
        do_reset();
        init_sequence();
        fetch(1, 32'd0, 1, 32'd0, 0);
        fetch(1, 32'd1, 1, 32'd4, 0);
        fetch(1, 32'd3, 1, 32'd12, 0);
        fetch(1, 32'd4, 1, 32'd16, 0);
        tick();
        tick();

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
